// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle for ahb_slave_mem.
// Signals (master view):
//   HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0],
//   HWDATA[31:0], HREADY  -> driven towards the slave
//   HRDATA[31:0], HREADYOUT, HRESP[1:0] -> returned by the slave
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with a 256 x 32-bit memory window at BASE_ADDR.
// Legal transfers get WAIT_STATES data-phase wait cycles; illegal size,
// misalignment or out-of-window addresses get a two-cycle ERROR response.
// Ports:
//   HCLK   - clock, all state changes on the rising edge
//   HRESET - synchronous active-high reset (memory contents are kept)
//   bus    - AHB slave modport (address/control/data in, HRDATA/HREADYOUT/HRESP out)
module ahb_slave_mem #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic            HCLK,
    input logic            HRESET,
    ahb_slave_mem_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        load;
    logic [7:0]  idx_q;
    logic [3:0]  strb_q;
    logic        write_q;
    logic [31:0] mem [256];

    logic        accept;
    logic        align_ok;
    logic        legal;
    logic [3:0]  strb;
    logic        burst_unused;

    // Burst type does not affect behaviour; every beat is checked on its own.
    assign burst_unused = ^bus.HBURST;

    // Only states that end with HREADYOUT high may take a new address phase.
    assign accept = (state == S_IDLE || state == S_DATA || state == S_ERR2) &&
                    bus.HSEL && bus.HREADY && bus.HTRANS[1];

    always_comb begin
        align_ok = 1'b0;
        strb     = 4'b1111;
        case (bus.HSIZE)
            3'd0: begin
                align_ok = 1'b1;
                strb     = 4'b0001 << bus.HADDR[1:0];
            end
            3'd1: begin
                align_ok = ~bus.HADDR[0];
                strb     = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                align_ok = (bus.HADDR[1:0] == 2'b00);
                strb     = 4'b1111;
            end
            default: begin
                align_ok = 1'b0;
                strb     = 4'b1111;
            end
        endcase
    end

    assign legal = align_ok && (bus.HADDR[31:10] == BASE_ADDR[31:10]);

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        load          = 1'b0;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = RESP_OKAY;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (state == S_ERR2) begin
                    bus.HRESP = RESP_ERROR;
                end
                if (accept) begin
                    load = 1'b1;
                    if (!legal) begin
                        state_nx = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_nx = S_DATA;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = 4'(WAIT_STATES);
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                bus.HREADYOUT = 1'b0;
                cnt_nx        = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = S_DATA;
                end
            end
            S_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = RESP_ERROR;
                state_nx      = S_ERR2;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                idx_q   <= bus.HADDR[9:2];
                strb_q  <= strb;
                write_q <= bus.HWRITE;
            end
        end
    end

    // Write lands on the edge that closes the DATA phase; a reset on that
    // same edge drops it. No reset branch so contents survive HRESET.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == S_DATA && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign bus.HRDATA = (state == S_DATA && !write_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: two instances (0 and 2 wait states)
// on one shared AHB bus, a directed vector table, hand sequences for the
// multi-cycle corner cases, and randomized traffic against a byte-level model.
module tb_ahb_slave_mem;
    localparam int W0 = 0;
    localparam int W2 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel0 = 1'b0, hsel2 = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd0, hburst = 3'd0;
    logic        dp_dut = 1'b0;
    logic        hready;
    logic [1:0]  cresp;
    logic [31:0] crdata;

    ahb_slave_mem_if bus0 ();
    ahb_slave_mem_if bus2 ();

    ahb_slave_mem #(.WAIT_STATES(W0), .BASE_ADDR(32'h0000_0000)) dut0 (
        .HCLK(clk), .HRESET(rst), .bus(bus0));
    ahb_slave_mem #(.WAIT_STATES(W2), .BASE_ADDR(32'h0000_0000)) dut2 (
        .HCLK(clk), .HRESET(rst), .bus(bus2));

    assign bus0.HSEL = hsel0;   assign bus2.HSEL = hsel2;
    assign bus0.HADDR = haddr;  assign bus2.HADDR = haddr;
    assign bus0.HTRANS = htrans; assign bus2.HTRANS = htrans;
    assign bus0.HWRITE = hwrite; assign bus2.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;  assign bus2.HSIZE = hsize;
    assign bus0.HBURST = hburst; assign bus2.HBURST = hburst;
    assign bus0.HWDATA = hwdata; assign bus2.HWDATA = hwdata;
    // Bus ready comes from whichever slave owns the current data phase.
    assign hready = dp_dut ? bus2.HREADYOUT : bus0.HREADYOUT;
    assign bus0.HREADY = hready; assign bus2.HREADY = hready;
    assign cresp  = dp_dut ? bus2.HRESP : bus0.HRESP;
    assign crdata = dp_dut ? bus2.HRDATA : bus0.HRDATA;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte-addressed memory per instance plus known flags.
    bit [7:0] mm [2][1024];
    bit       mk [2][1024];

    typedef struct {
        bit        act;
        bit        dut;
        int        kind;   // 0 = no transfer, 1 = legal, 2 = illegal
        bit        wr;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [31:0] wdata;
    } ph_t;
    ph_t pend;

    logic [1:0]  last_resp, last_wait_resp;
    int          last_waits;
    logic [31:0] last_rdata;

    typedef struct {
        bit        sel;
        bit [1:0]  tr;
        bit        wr;
        bit [2:0]  sz;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [1:0]  resp;
        int        waits;
        bit [31:0] rdata;
        bit        chk_rd;
    } vec_t;
    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit legal(input bit [31:0] a, input bit [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if ((a % (32'd1 << sz)) != 0) return 1'b0;
        return a < 32'd1024;
    endfunction

    task automatic model_word(input bit d, input bit [31:0] a,
                              output bit [31:0] e, output bit [31:0] m);
        int base;
        base = int'(a % 1024) / 4 * 4;
        e = '0;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            e[8*b +: 8] = mm[d][base + b];
            m[8*b +: 8] = mk[d][base + b] ? 8'hFF : 8'h00;
        end
    endtask

    task automatic model_write(input bit d, input bit [31:0] a, input bit [2:0] sz,
                               input bit [31:0] wd);
        int base, off;
        base = int'(a % 1024) / 4 * 4;
        off  = int'(a % 4);
        for (int b = off; b < off + (1 << sz); b++) begin
            mm[d][base + b] = wd[8*b +: 8];
            mk[d][base + b] = 1'b1;
        end
    endtask

    // One address phase; completes and checks the previous data phase.
    task automatic step(input bit d, input bit sel, input bit [1:0] tr, input bit wr,
                        input bit [2:0] sz, input bit [31:0] a, input bit [31:0] wd);
        int w;
        bit done;
        bit [31:0] e, m;
        int ew;
        hsel0  = sel && !d;
        hsel2  = sel && d;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hburst = 3'($urandom);
        hwdata = pend.act ? pend.wdata : $urandom;
        w = 0;
        done = 1'b0;
        last_wait_resp = 2'b00;
        while (!done) begin
            @(negedge clk);
            if (!hready) begin
                w++;
                if (w == 1) last_wait_resp = cresp;
                if (pend.act) chk("wait_resp", 32'(cresp), (pend.kind == 2) ? 32'd1 : 32'd0);
                if (w > 20) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ready_timeout: got %0d wait cycles expected at most 16", w);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                end
            end else begin
                done = 1'b1;
            end
        end
        last_resp  = cresp;
        last_waits = w;
        last_rdata = crdata;
        if (pend.act) begin
            ew = (pend.kind == 2) ? 1 : (pend.kind == 1) ? (pend.dut ? W2 : W0) : 0;
            chk("waits", 32'(w), 32'(ew));
            chk("resp", 32'(cresp), (pend.kind == 2) ? 32'd1 : 32'd0);
            if (pend.kind == 1 && !pend.wr) begin
                model_word(pend.dut, pend.addr, e, m);
                if (m != 0) chk("rdata", crdata & m, e & m);
            end else if (pend.kind != 1) begin
                chk("rdata_zero", crdata, 32'h0);
            end
        end
        @(posedge clk);
        if (pend.act && pend.kind == 1 && pend.wr)
            model_write(pend.dut, pend.addr, pend.size, hwdata);
        #1;
        dp_dut     = d;
        pend.act   = 1'b1;
        pend.dut   = d;
        pend.wr    = wr;
        pend.addr  = a;
        pend.size  = sz;
        pend.wdata = wd;
        pend.kind  = !(sel && tr[1]) ? 0 : (legal(a, sz) ? 1 : 2);
    endtask

    task automatic idle(input bit d);
        step(d, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic rd_word(input bit d, input bit [31:0] a, input string nm,
                           input bit [31:0] exp);
        step(d, 1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0);
        idle(d);
        chk(nm, last_rdata, exp);
    endtask

    initial begin
        pend = '{act: 1'b0, dut: 1'b0, kind: 0, wr: 1'b0, addr: '0, size: '0, wdata: '0};

        //        sel tr     wr sz    addr        wdata          resp  w  rdata         chk
        tbl[0]  = '{1, 2'b10, 1, 3'd2, 32'h3FC, 32'hAABBCCDD, 2'b00, 0, 32'h0,        0};
        tbl[1]  = '{1, 2'b10, 1, 3'd0, 32'h3FE, 32'h00120000, 2'b00, 0, 32'h0,        0};
        tbl[2]  = '{1, 2'b10, 0, 3'd2, 32'h3FC, 32'h0,        2'b00, 0, 32'hAA12CCDD, 1};
        tbl[3]  = '{1, 2'b10, 1, 3'd2, 32'h100, 32'h11223344, 2'b00, 0, 32'h0,        0};
        tbl[4]  = '{1, 2'b11, 1, 3'd1, 32'h102, 32'hBEEF0000, 2'b00, 0, 32'h0,        0};
        tbl[5]  = '{1, 2'b10, 0, 3'd2, 32'h100, 32'h0,        2'b00, 0, 32'hBEEF3344, 1};
        tbl[6]  = '{1, 2'b10, 1, 3'd1, 32'h100, 32'h00005566, 2'b00, 0, 32'h0,        0};
        tbl[7]  = '{1, 2'b10, 0, 3'd1, 32'h102, 32'h0,        2'b00, 0, 32'hBEEF5566, 1};
        tbl[8]  = '{1, 2'b10, 1, 3'd1, 32'h101, 32'hFFFFFFFF, 2'b01, 1, 32'h0,        1};
        tbl[9]  = '{1, 2'b10, 0, 3'd2, 32'h102, 32'h0,        2'b01, 1, 32'h0,        1};
        tbl[10] = '{1, 2'b10, 0, 3'd0, 32'h103, 32'h0,        2'b00, 0, 32'hBEEF5566, 1};
        tbl[11] = '{1, 2'b10, 1, 3'd2, 32'h00C, 32'hCAFEF00D, 2'b00, 0, 32'h0,        0};
        tbl[12] = '{1, 2'b10, 1, 3'd3, 32'h00C, 32'hFFFFFFFF, 2'b01, 1, 32'h0,        1};
        tbl[13] = '{1, 2'b10, 0, 3'd2, 32'h00C, 32'h0,        2'b00, 0, 32'hCAFEF00D, 1};
        tbl[14] = '{1, 2'b00, 0, 3'd2, 32'h00C, 32'h0,        2'b00, 0, 32'h0,        1};
        tbl[15] = '{0, 2'b10, 0, 3'd2, 32'h00C, 32'h0,        2'b00, 0, 32'h0,        1};
        tbl[16] = '{1, 2'b10, 0, 3'd2, 32'h800, 32'h0,        2'b01, 1, 32'h0,        1};
        tbl[17] = '{1, 2'b01, 1, 3'd2, 32'h00C, 32'hDEADBEEF, 2'b00, 0, 32'h0,        1};
        tbl[18] = '{1, 2'b10, 0, 3'd2, 32'h00C, 32'h0,        2'b00, 0, 32'hCAFEF00D, 1};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(bus0.HREADYOUT), 32'd1);
        chk("rst_resp0",  32'(bus0.HRESP), 32'd0);
        chk("rst_rdata0", bus0.HRDATA, 32'h0);
        chk("rst_ready2", 32'(bus2.HREADYOUT), 32'd1);
        chk("rst_resp2",  32'(bus2.HRESP), 32'd0);
        chk("rst_rdata2", bus2.HRDATA, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed table on the zero-wait instance, pipelined back to back
        for (int i = 0; i <= 19; i++) begin
            if (i < 19)
                step(1'b0, tbl[i].sel, tbl[i].tr, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wdata);
            else
                idle(1'b0);
            if (i > 0) begin
                chk($sformatf("tbl%0d_resp", i - 1), 32'(last_resp), 32'(tbl[i-1].resp));
                chk($sformatf("tbl%0d_waits", i - 1), 32'(last_waits), 32'(tbl[i-1].waits));
                if (tbl[i-1].chk_rd)
                    chk($sformatf("tbl%0d_rdata", i - 1), last_rdata, tbl[i-1].rdata);
            end
        end

        // Word INCR4 from 0x3FC crossing out of the window
        step(1'b0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h000, 32'h0BADF00D);
        step(1'b0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h3FC, 32'h01020304);
        step(1'b0, 1'b1, 2'b11, 1'b1, 3'd2, 32'h400, 32'hFFFFFFFF);
        chk("incr_beat1_resp", 32'(last_resp), 32'd0);
        chk("incr_beat1_waits", 32'(last_waits), 32'd0);
        step(1'b0, 1'b1, 2'b11, 1'b1, 3'd2, 32'h404, 32'hFFFFFFFF);
        chk("incr_x_waits", 32'(last_waits), 32'd1);
        chk("incr_x_err1_resp", 32'(last_wait_resp), 32'd1);
        chk("incr_x_err2_resp", 32'(last_resp), 32'd1);
        step(1'b0, 1'b1, 2'b11, 1'b1, 3'd2, 32'h408, 32'hFFFFFFFF);
        idle(1'b0);
        rd_word(1'b0, 32'h000, "incr_alias_word0", 32'h0BADF00D);
        rd_word(1'b0, 32'h3FC, "incr_beat1_data", 32'h01020304);

        // BUSY between SEQ beats
        step(1'b0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h020, 32'h11111111);
        step(1'b0, 1'b1, 2'b01, 1'b1, 3'd2, 32'h024, 32'h99999999);
        step(1'b0, 1'b1, 2'b11, 1'b1, 3'd2, 32'h024, 32'h22222222);
        chk("busy_resp", 32'(last_resp), 32'd0);
        step(1'b0, 1'b1, 2'b11, 1'b1, 3'd2, 32'h028, 32'h33333333);
        chk("busy_waits", 32'(last_waits), 32'd0);
        idle(1'b0);
        rd_word(1'b0, 32'h020, "busy_w0", 32'h11111111);
        rd_word(1'b0, 32'h024, "busy_w1", 32'h22222222);
        rd_word(1'b0, 32'h028, "busy_w2", 32'h33333333);

        // Two wait states
        step(1'b1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h000, 32'h00000004);
        idle(1'b1);
        chk("ws2_write_waits", 32'(last_waits), 32'd2);
        chk("ws2_write_resp", 32'(last_resp), 32'd0);
        step(1'b1, 1'b1, 2'b10, 1'b0, 3'd2, 32'h000, 32'h0);
        idle(1'b1);
        chk("ws2_read_waits", 32'(last_waits), 32'd2);
        chk("ws2_read_data", last_rdata, 32'h00000004);

        // Reset while a write sits in WAIT
        step(1'b1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h010, 32'h55AA55AA);
        idle(1'b1);
        step(1'b1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h010, 32'h12345678);
        hsel2 = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pend.act = 1'b0;
        @(negedge clk);
        chk("wrst_ready", 32'(bus2.HREADYOUT), 32'd1);
        chk("wrst_resp", 32'(bus2.HRESP), 32'd0);
        chk("wrst_rdata", bus2.HRDATA, 32'h0);
        @(negedge clk);
        chk("wrst_still_idle", 32'(bus2.HREADYOUT), 32'd1);
        @(posedge clk);
        #1;
        rd_word(1'b1, 32'h010, "wrst_word4", 32'h55AA55AA);
        rd_word(1'b0, 32'h3FC, "mem_kept_after_rst", 32'h01020304);

        // Randomized traffic across both instances
        for (int i = 0; i < 800; i++) begin
            bit d, sel, wr;
            bit [1:0] tr;
            bit [2:0] sz;
            bit [31:0] a;
            int r;
            d   = ($urandom_range(0, 3) == 0);
            sel = ($urandom_range(0, 9) != 0);
            tr  = 2'($urandom);
            wr  = 1'($urandom);
            r   = $urandom_range(0, 11);
            sz  = (r < 10) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            r   = $urandom_range(0, 19);
            if (r < 10)      a = $urandom_range(0, 63);
            else if (r < 18) a = $urandom_range(0, 1023);
            else             a = $urandom;
            if ($urandom_range(0, 9) < 8 && sz <= 3'd2)
                a = a & ~((32'd1 << sz) - 32'd1);
            step(d, sel, tr, wr, sz, a, $urandom);
        end
        idle(1'b0);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
